sm83_alu_seq: RTL and testbench

Micro-sequencer that sits directly upstream of the 4-bit SM83 ALU datapath. It accepts one 8-bit arithmetic/logic request over a valid/ready handshake and loads both operands into the ALU. It then drives the low-nibble and high-nibble passes and returns the 8-bit result with the SM83 flag nibble (Z N H C) over a second valid/ready handshake. All ALU control lines it drives are registered and held for full cycles; the ALU samples its operand loads on the falling edge inside those cycles.

---
 rtl/sm83_alu_seq.sv | 247 ++++++++++++++++++++++++
 tb/tb_sm83_alu_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sm83_alu_seq.sv
// Micro-sequencer for the 4-bit SM83 ALU datapath: loads A and B, runs the low and high
// nibble passes, then returns the 8-bit result with the {Z,N,H,C} flag nibble.
module sm83_alu_seq (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [3:0] op,
    input  logic [7:0] opnd_a,
    input  logic [7:0] opnd_b,
    input  logic [3:0] flags_in,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] result,
    output logic [3:0] flags_out,
    output logic [7:0] alu_din,
    output logic       alu_load_a,
    output logic       alu_load_b,
    output logic       alu_load_b_zero,
    output logic       alu_shift_oe,
    output logic       alu_result_oe,
    output logic       alu_op_low,
    output logic       alu_op_b_high,
    output logic       alu_negate,
    output logic       alu_carry_in,
    output logic       alu_force_carry,
    output logic       alu_ignore_carry,
    output logic       alu_no_carry_out,
    input  logic [7:0] alu_dout,
    input  logic       alu_carry,
    input  logic       alu_zero
);

    // Handshakes: a transfer happens on the rising edge where valid && ready are both high;
    // op_ready is high only in IDLE, res_valid only in DONE, and DONE holds until res_ready.

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_CP  = 4'd7;
    localparam logic [3:0] OP_INC = 4'd8;
    localparam logic [3:0] OP_DEC = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LD_A = 3'd1,
        S_LD_B = 3'd2,
        S_LO   = 3'd3,
        S_HI   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    typedef struct packed {
        logic load_a;
        logic load_b;
        logic load_b_zero;
        logic shift_oe;
        logic result_oe;
        logic op_low;
        logic op_b_high;
        logic negate;
        logic carry_in;
        logic force_carry;
        logic ignore_carry;
        logic no_carry_out;
    } ctrl_t;

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [3:0] fl_q, fl_d;
    logic       hc_q, hc_d;
    logic [7:0] result_q, result_d;
    logic [3:0] flags_q, flags_d;
    logic       op_ready_q, op_ready_d;
    logic       res_valid_q, res_valid_d;
    logic [7:0] din_q, din_d;
    ctrl_t      ctrl_q, ctrl_d;

    logic       neg_op, cin_lo, force_op, ignore_op, nco_op;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        fl_d     = fl_q;
        hc_d     = hc_q;
        result_d = result_q;
        flags_d  = flags_q;

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    op_d    = op;
                    a_d     = opnd_a;
                    b_d     = opnd_b;
                    fl_d    = flags_in;
                    state_d = S_LD_A;
                end
            end
            S_LD_A: state_d = S_LD_B;
            S_LD_B: state_d = S_LO;
            S_LO: begin
                hc_d    = alu_carry;
                state_d = S_HI;
            end
            S_HI: begin
                result_d = alu_dout;
                case (op_q)
                    OP_ADD, OP_ADC: flags_d = {alu_zero, 1'b0, hc_q, alu_carry};
                    OP_SUB, OP_SBC: flags_d = {alu_zero, 1'b1, !hc_q, !alu_carry};
                    OP_CP: begin
                        result_d = a_q;
                        flags_d  = {alu_zero, 1'b1, !hc_q, !alu_carry};
                    end
                    OP_AND:        flags_d = {alu_zero, 1'b0, 1'b1, 1'b0};
                    OP_XOR, OP_OR: flags_d = {alu_zero, 1'b0, 1'b0, 1'b0};
                    OP_INC:        flags_d = {alu_zero, 1'b0, hc_q, fl_q[0]};
                    OP_DEC:        flags_d = {alu_zero, 1'b1, !hc_q, fl_q[0]};
                    default: begin
                        result_d = a_q;
                        flags_d  = fl_q;
                    end
                endcase
                state_d = S_DONE;
            end
            S_DONE: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Per-op chain controls; NOP codes fall through to ADD (all zero).
    always_comb begin
        neg_op    = 1'b0;
        cin_lo    = 1'b0;
        force_op  = 1'b0;
        ignore_op = 1'b0;
        nco_op    = 1'b0;
        case (op_d)
            OP_ADC:        cin_lo = fl_d[0];
            OP_SUB, OP_CP: begin neg_op = 1'b1; cin_lo = 1'b1; end
            OP_SBC:        begin neg_op = 1'b1; cin_lo = !fl_d[0]; end
            OP_AND:        begin cin_lo = 1'b1; force_op = 1'b1; end
            OP_XOR:        nco_op = 1'b1;
            OP_OR:         begin force_op = 1'b1; ignore_op = 1'b1; nco_op = 1'b1; end
            OP_INC:        cin_lo = 1'b1;
            OP_DEC:        neg_op = 1'b1;
            default:       ;
        endcase
    end

    // Controls are decoded from the next state so every ALU line is a flop held for the full cycle.
    always_comb begin
        ctrl_d = '0;
        din_d  = 8'h00;
        case (state_d)
            S_LD_A: begin
                din_d           = a_d;
                ctrl_d.shift_oe = 1'b1;
                ctrl_d.load_a   = 1'b1;
            end
            S_LD_B: begin
                din_d           = b_d;
                ctrl_d.shift_oe = 1'b1;
                if (op_d == OP_INC || op_d == OP_DEC) ctrl_d.load_b_zero = 1'b1;
                else                                  ctrl_d.load_b      = 1'b1;
            end
            S_LO: begin
                ctrl_d.op_low       = 1'b1;
                ctrl_d.negate       = neg_op;
                ctrl_d.carry_in     = cin_lo;
                ctrl_d.force_carry  = force_op;
                ctrl_d.ignore_carry = ignore_op;
                ctrl_d.no_carry_out = nco_op;
            end
            S_HI: begin
                ctrl_d.op_b_high    = 1'b1;
                ctrl_d.result_oe    = 1'b1;
                ctrl_d.negate       = neg_op;
                ctrl_d.carry_in     = hc_d;
                ctrl_d.force_carry  = force_op;
                ctrl_d.ignore_carry = ignore_op;
                ctrl_d.no_carry_out = nco_op;
            end
            default: ;
        endcase
        op_ready_d  = (state_d == S_IDLE);
        res_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= 4'h0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            fl_q        <= 4'h0;
            hc_q        <= 1'b0;
            result_q    <= 8'h00;
            flags_q     <= 4'h0;
            op_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            din_q       <= 8'h00;
            ctrl_q      <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            fl_q        <= fl_d;
            hc_q        <= hc_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            op_ready_q  <= op_ready_d;
            res_valid_q <= res_valid_d;
            din_q       <= din_d;
            ctrl_q      <= ctrl_d;
        end
    end

    assign op_ready         = op_ready_q;
    assign res_valid        = res_valid_q;
    assign result           = result_q;
    assign flags_out        = flags_q;
    assign alu_din          = din_q;
    assign alu_load_a       = ctrl_q.load_a;
    assign alu_load_b       = ctrl_q.load_b;
    assign alu_load_b_zero  = ctrl_q.load_b_zero;
    assign alu_shift_oe     = ctrl_q.shift_oe;
    assign alu_result_oe    = ctrl_q.result_oe;
    assign alu_op_low       = ctrl_q.op_low;
    assign alu_op_b_high    = ctrl_q.op_b_high;
    assign alu_negate       = ctrl_q.negate;
    assign alu_carry_in     = ctrl_q.carry_in;
    assign alu_force_carry  = ctrl_q.force_carry;
    assign alu_ignore_carry = ctrl_q.ignore_carry;
    assign alu_no_carry_out = ctrl_q.no_carry_out;

endmodule

// File: tb/tb_sm83_alu_seq.sv
// Bench for sm83_alu_seq: a nibble-serial ALU stand-in drives the ALU inputs, and results
// are compared with a byte-level arithmetic model of the SM83 flag rules.
module tb_sm83_alu_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [3:0] op = 4'h0;
  logic [7:0] opnd_a = 8'h00;
  logic [7:0] opnd_b = 8'h00;
  logic [3:0] flags_in = 4'h0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] result;
  logic [3:0] flags_out;
  logic [7:0] alu_din;
  logic       alu_load_a, alu_load_b, alu_load_b_zero, alu_shift_oe, alu_result_oe;
  logic       alu_op_low, alu_op_b_high, alu_negate, alu_carry_in;
  logic       alu_force_carry, alu_ignore_carry, alu_no_carry_out;
  logic [7:0] alu_dout;
  logic       alu_carry, alu_zero;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  sm83_alu_seq dut (
    .clk(clk), .reset_n(reset_n),
    .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .opnd_a(opnd_a), .opnd_b(opnd_b), .flags_in(flags_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .flags_out(flags_out),
    .alu_din(alu_din), .alu_load_a(alu_load_a), .alu_load_b(alu_load_b),
    .alu_load_b_zero(alu_load_b_zero), .alu_shift_oe(alu_shift_oe),
    .alu_result_oe(alu_result_oe), .alu_op_low(alu_op_low),
    .alu_op_b_high(alu_op_b_high), .alu_negate(alu_negate),
    .alu_carry_in(alu_carry_in), .alu_force_carry(alu_force_carry),
    .alu_ignore_carry(alu_ignore_carry), .alu_no_carry_out(alu_no_carry_out),
    .alu_dout(alu_dout), .alu_carry(alu_carry), .alu_zero(alu_zero)
  );

  // clock
  always #5 clk = ~clk;

  // ALU stand-in: operand and low-nibble latches sample on the falling edge
  logic [7:0] m_a = 8'h00;
  logic [7:0] m_b = 8'h00;
  logic [3:0] m_lo = 4'h0;
  logic [3:0] an, bn, core_res;
  logic       core_c;
  logic [4:0] sum;

  always @(negedge clk) begin
    if (alu_load_a) m_a <= alu_din;
    if (alu_load_b) m_b <= alu_din;
    else if (alu_load_b_zero) m_b <= 8'h00;
    if (alu_op_low) m_lo <= core_res;
  end

  always_comb begin
    an = alu_op_low ? m_a[3:0] : m_a[7:4];
    bn = alu_op_b_high ? m_b[7:4] : m_b[3:0];
    if (alu_negate) bn = ~bn;
    sum = {1'b0, an} + {1'b0, bn} + {4'b0000, alu_carry_in};
    if (alu_force_carry && alu_ignore_carry && alu_no_carry_out) begin
      core_res = an | bn;
      core_c = 1'b0;
    end else if (alu_force_carry) begin
      core_res = an & bn;
      core_c = 1'b1;
    end else if (alu_no_carry_out) begin
      core_res = an ^ bn;
      core_c = 1'b0;
    end else begin
      core_res = sum[3:0];
      core_c = sum[4];
    end
    alu_dout = alu_result_oe ? {core_res, m_lo} : 8'h00;
    alu_zero = (alu_dout == 8'h00);
    alu_carry = core_c;
  end

  // byte-level reference: returns {result, Z, N, H, C}
  function automatic logic [11:0] model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] fl);
    int ia, ib, k, v;
    logic [7:0] outv;
    logic zf, nf, hf, cf;
    ia = int'(a);
    ib = int'(b);
    k = 0;
    v = 0;
    outv = a;
    zf = fl[3]; nf = fl[2]; hf = fl[1]; cf = fl[0];
    case (o)
      4'd0, 4'd1: begin
        k = (o == 4'd1) ? int'(fl[0]) : 0;
        v = ia + ib + k;
        outv = 8'(v);
        zf = (outv == 8'h00); nf = 1'b0;
        hf = ((ia % 16) + (ib % 16) + k) > 15;
        cf = v > 255;
      end
      4'd2, 4'd3, 4'd7: begin
        k = (o == 4'd3) ? int'(fl[0]) : 0;
        v = ia - ib - k;
        outv = (o == 4'd7) ? a : 8'(v);
        zf = (8'(v) == 8'h00); nf = 1'b1;
        hf = (ia % 16) < ((ib % 16) + k);
        cf = ia < (ib + k);
      end
      4'd4: begin outv = a & b; zf = (outv == 8'h00); nf = 1'b0; hf = 1'b1; cf = 1'b0; end
      4'd5: begin outv = a ^ b; zf = (outv == 8'h00); nf = 1'b0; hf = 1'b0; cf = 1'b0; end
      4'd6: begin outv = a | b; zf = (outv == 8'h00); nf = 1'b0; hf = 1'b0; cf = 1'b0; end
      4'd8: begin outv = a + 8'd1; zf = (outv == 8'h00); nf = 1'b0; hf = (ia % 16) == 15; end
      4'd9: begin outv = a - 8'd1; zf = (outv == 8'h00); nf = 1'b1; hf = (ia % 16) == 0; end
      default: ;
    endcase
    return {outv, zf, nf, hf, cf};
  endfunction

  function automatic logic exp_negate(input logic [3:0] o);
    return (o == 4'd2) || (o == 4'd3) || (o == 4'd7) || (o == 4'd9);
  endfunction

  function automatic logic exp_cin_lo(input logic [3:0] o, input logic c);
    case (o)
      4'd1: return c;
      4'd2, 4'd4, 4'd7, 4'd8: return 1'b1;
      4'd3: return !c;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // one full transaction; hold = cycles res_ready stays low after res_valid, with a competing op_valid
  task automatic run_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] fl, input int hold);
    logic [11:0] expv;
    logic [7:0]  r0;
    logic [3:0]  f0;
    logic        incdec;
    int          waits;
    incdec = (o == 4'd8) || (o == 4'd9);
    exp_q.push_back(model(o, a, b, fl));
    op = o; opnd_a = a; opnd_b = b; flags_in = fl;
    op_valid = 1'b1;
    res_ready = 1'b0;
    waits = 0;
    while (!op_ready && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    check("accept_ready", 32'(op_ready), 32'd1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    check("lda_ctrl", {alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe, alu_din},
          {1'b1, 1'b0, 1'b1, 1'b0, a});
    check("busy_ready", {op_ready, res_valid}, {1'b0, 1'b0});
    @(posedge clk); #1;
    check("ldb_ctrl", {alu_load_a, alu_load_b, alu_load_b_zero, alu_shift_oe, alu_din},
          {1'b0, !incdec, incdec, 1'b1, b});
    @(posedge clk); #1;
    check("lo_ctrl", {alu_op_low, alu_op_b_high, alu_result_oe, alu_shift_oe, alu_negate, alu_carry_in},
          {1'b1, 1'b0, 1'b0, 1'b0, exp_negate(o), exp_cin_lo(o, fl[0])});
    @(posedge clk); #1;
    check("hi_ctrl", {alu_op_low, alu_op_b_high, alu_result_oe, alu_negate, res_valid},
          {1'b0, 1'b1, 1'b1, exp_negate(o), 1'b0});
    @(posedge clk); #1;
    check("latency", 32'(res_valid), 32'd1);
    expv = exp_q.pop_front();
    check("result", 32'(result), 32'(expv[11:4]));
    check("flags", 32'(flags_out), 32'(expv[3:0]));
    r0 = result;
    f0 = flags_out;
    for (int i = 0; i < hold; i++) begin
      op_valid = 1'b1;
      op = 4'(op + 4'd1);
      @(posedge clk); #1;
      check("hold_stable", {res_valid, op_ready, alu_load_a, result, flags_out},
            {1'b1, 1'b0, 1'b0, r0, f0});
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("post_handshake", {res_valid, op_ready, alu_load_a}, {1'b0, 1'b1, 1'b0});
    op_valid = 1'b0;
  endtask

  initial begin
    // reset
    reset_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_state", {op_ready, res_valid, result, flags_out, alu_din},
          {1'b1, 1'b0, 8'h00, 4'h0, 8'h00});
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    run_op(4'd0, 8'h3A, 8'hC6, 4'b0000, 0);
    run_op(4'd2, 8'h10, 8'h01, 4'b0000, 0);
    run_op(4'd1, 8'hFF, 8'h00, 4'b0001, 0);
    run_op(4'd4, 8'h0F, 8'hF0, 4'b0000, 0);
    run_op(4'd6, 8'h0F, 8'hF0, 4'b1111, 0);
    run_op(4'd9, 8'h00, 8'h55, 4'b0001, 0);
    run_op(4'd7, 8'h42, 8'h42, 4'b0000, 0);
    run_op(4'd5, 8'hA5, 8'hA5, 4'b0000, 0);
    run_op(4'd8, 8'hFF, 8'h12, 4'b0000, 0);
    run_op(4'd3, 8'h00, 8'h00, 4'b0001, 0);
    run_op(4'd12, 8'h77, 8'h11, 4'b1010, 0);

    // backpressure with a competing request held on op_valid
    run_op(4'd0, 8'h81, 8'h82, 4'b0000, 3);
    run_op(4'd2, 8'h05, 8'h09, 4'b0000, 0);

    // asynchronous reset during the low-nibble pass
    op = 4'd2; opnd_a = 8'h34; opnd_b = 8'h12; flags_in = 4'h0;
    op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("in_lo", 32'(alu_op_low), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("reset_mid_op", {op_ready, res_valid, result, flags_out, alu_din,
                           alu_load_a, alu_load_b, alu_load_b_zero, alu_shift_oe, alu_result_oe,
                           alu_op_low, alu_op_b_high, alu_negate, alu_carry_in,
                           alu_force_carry, alu_ignore_carry, alu_no_carry_out},
          {1'b1, 1'b0, 8'h00, 4'h0, 8'h00, 12'h000});
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("after_reset", {op_ready, res_valid}, {1'b1, 1'b0});
    run_op(4'd0, 8'h0F, 8'h01, 4'b0000, 0);

    // randomized
    for (int i = 0; i < 60; i++) begin
      run_op(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
